// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state type, bus widths and parameter defaults for the SDRAM port arbiter
package sdram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam int AW = 26;
   localparam int DW = 64;
   localparam int NPORTS_DEF = 4;
   localparam int RFSH_DEF = 480;
   localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester ports plus SDRAM burst channel; master is the arbiter side
interface sdram_port_arbiter_if import sdram_arb_pkg::*; #(parameter int NPORTS = NPORTS_DEF);
   logic [NPORTS-1:0] p_req, p_ack;
   logic [NPORTS-1:0][AW-1:0] p_addr;
   logic [DW-1:0] p_dout, sd_dout;
   logic [AW-1:0] sd_addr;
   logic sd_req, sd_ready, do_refresh, timeout_err;
   modport master (input p_req, p_addr, sd_ready, sd_dout,
                   output p_ack, p_dout, sd_req, sd_addr, do_refresh, timeout_err);
   modport slave (output p_req, p_addr, sd_ready, sd_dout,
                  input p_ack, p_dout, sd_req, sd_addr, do_refresh, timeout_err);
endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts one past last_grant
module rr_pick #(
   parameter int NPORTS = 4,
   parameter int LW = 2
) (
   input  logic [NPORTS-1:0] req,
   input  logic [LW-1:0]     last_grant,
   output logic              valid,
   output logic [LW-1:0]     index
);
   logic [LW-1:0] c;
   assign valid = |req;
   // scanning from farthest to nearest lets the nearest requester overwrite
   always_comb begin
      index = last_grant;
      c = last_grant;
      for (int i = NPORTS; i >= 1; i--) begin
         c = LW'((int'(last_grant) + i) % NPORTS);
         if (req[c]) index = c;
      end
   end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM burst channel among NPORTS requesters,
// with request timeout and idle-time refresh hints
module sdram_port_arbiter import sdram_arb_pkg::*; #(
   parameter int NPORTS        = NPORTS_DEF,
   parameter int RFSH_INTERVAL = RFSH_DEF,
   parameter int TIMEOUT       = TIMEOUT_DEF
) (
   input logic clk,
   input logic reset,
   sdram_port_arbiter_if.master bus
);
   localparam int LW = NPORTS > 1 ? $clog2(NPORTS) : 1;
   localparam int TW = $clog2(TIMEOUT + 2);
   state_t state, state_n;
   logic [LW-1:0] g, g_n, last, last_n, pick;
   logic pick_valid;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [9:0] rcnt, rcnt_n;
   logic [NPORTS-1:0] ack_n;
   logic [DW-1:0] dout_n;
   logic [AW-1:0] addr_n;
   logic sd_req_n, rfsh_n, terr_n;

   rr_pick #(.NPORTS(NPORTS), .LW(LW)) u_pick (
      .req(bus.p_req), .last_grant(last), .valid(pick_valid), .index(pick)
   );

   always_comb begin
      state_n = state;
      g_n = g;
      last_n = last;
      tcnt_n = tcnt;
      rcnt_n = rcnt + 10'(rcnt != '1);
      ack_n = '0;
      dout_n = bus.p_dout;
      addr_n = bus.sd_addr;
      sd_req_n = 1'b0;
      rfsh_n = 1'b0;
      terr_n = bus.timeout_err;
      case (state)
         IDLE: if (pick_valid) begin
            g_n = pick;
            last_n = pick;
            addr_n = bus.p_addr[pick];
            sd_req_n = 1'b1;
            tcnt_n = '0;
            state_n = ISSUE;
         end else if (rcnt >= 10'(RFSH_INTERVAL)) begin
            rfsh_n = 1'b1;
            rcnt_n = '0;
         end
         ISSUE, WAIT: begin
            state_n = WAIT;
            if (bus.sd_ready) begin
               dout_n = bus.sd_dout;
               ack_n[g] = 1'b1;
               state_n = DONE;
            end else if (tcnt == TW'(TIMEOUT)) begin
               dout_n = '0;
               ack_n[g] = 1'b1;
               terr_n = 1'b1;
               state_n = DONE;
            end else tcnt_n = tcnt + TW'(1);
         end
         // DONE never grants, so the acked port gets one cycle to drop p_req
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         g <= '0;
         last <= LW'(NPORTS - 1);
         tcnt <= '0;
         rcnt <= '0;
         bus.p_ack <= '0;
         bus.p_dout <= '0;
         bus.sd_req <= 1'b0;
         bus.sd_addr <= '0;
         bus.do_refresh <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         g <= g_n;
         last <= last_n;
         tcnt <= tcnt_n;
         rcnt <= rcnt_n;
         bus.p_ack <= ack_n;
         bus.p_dout <= dout_n;
         bus.sd_req <= sd_req_n;
         bus.sd_addr <= addr_n;
         bus.do_refresh <= rfsh_n;
         bus.timeout_err <= terr_n;
      end
   end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter NPORTS, default 4: number of requester ports sharing one SDRAM burst channel.
REQ-002 Parameter RFSH_INTERVAL, default 480: idle cycles between do_refresh pulses.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for sd_ready before aborting.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 p_req  in  NPORTS  per-port level request; held until p_ack.
REQ-007 p_addr  in  NPORTS x 26  per-port word address [26:1]; stable while p_req high.
REQ-008 p_ack  out  NPORTS  one-cycle completion pulse, at most one bit set.
REQ-009 p_dout  out  64  shared read data; valid in the p_ack cycle and held until the next p_ack.
REQ-010 sd_req  out  1  channel request to SDRAM controller (rising-edge sensitive).
REQ-011 sd_addr  out  26  address [26:1] presented with sd_req.
REQ-012 sd_ready  in  1  one-cycle burst-complete pulse from SDRAM controller.
REQ-013 sd_dout  in  64  burst data, valid when sd_ready=1.
REQ-014 do_refresh  out  1  one-cycle refresh hint to SDRAM controller.
REQ-015 timeout_err  out  1  sticky flag, set on any aborted transaction.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE with any p_req high: register winner g, sd_addr<=p_addr[g], sd_req<=1, go to ISSUE.
REQ-018 ISSUE: sd_req<=0, go to WAIT; sd_req SHALL be high for exactly one cycle per transaction.
REQ-019 WAIT (also ISSUE) with sd_ready=1: p_dout<=sd_dout, p_ack[g]<=1, go to DONE.
REQ-020 DONE: p_ack<=0, go to IDLE; port g SHALL NOT be re-granted in DONE, so it has one cycle to drop p_req.
REQ-021 Latency: p_req sampled in IDLE at edge N -> sd_req high after edge N; p_ack high one cycle after the sd_ready cycle.
REQ-022 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NPORTS, and last_grant<=g on each grant.
REQ-023 A p_req dropped before grant SHALL be treated as withdrawn; one dropped after grant SHALL still complete and pulse p_ack.
REQ-024 Timeout counter clears on entry to ISSUE and increments in ISSUE/WAIT; reaching TIMEOUT -> p_dout<=0, p_ack[g]<=1, timeout_err<=1, go to DONE.
REQ-025 sd_ready in IDLE or DONE SHALL be ignored (no ack, p_dout unchanged).
REQ-026 Refresh counter (10 bits, saturating) increments every cycle and clears on do_refresh.
REQ-027 In IDLE with no p_req and counter >= RFSH_INTERVAL: do_refresh<=1 for one cycle, counter<=0; never asserted outside IDLE.
REQ-028 With a request and the refresh condition true in the same IDLE cycle, the request SHALL win and refresh is deferred.

Reset
REQ-029 Reset SHALL force state IDLE, last_grant=NPORTS-1 (port 0 wins first), and clear both counters.
REQ-030 Reset values: p_ack=0, p_dout=0, sd_req=0, sd_addr=0, do_refresh=0, timeout_err=0.
REQ-031 Reset mid-transaction SHALL abandon it with no p_ack; a later stray sd_ready is ignored per REQ-025.

Structure
REQ-032 Package sdram_arb_pkg SHALL hold the state enum, the address-width constant (26), the data-width constant (64) and parameter defaults.
REQ-033 The round-robin picker SHALL be a sub-module rr_pick (inputs req vector and last_grant; outputs valid and index), combinational.

Verification
REQ-034 Single: p_req[2]=1, p_addr[2]=0x0123456; sd_ready 6 cycles after sd_req with sd_dout=0xDEADBEEF_CAFEF00D -> sd_addr=0x0123456, one sd_req pulse, p_ack[2] and that p_dout one cycle after sd_ready.
REQ-035 Fairness: all four p_req held high continuously -> grant order 0,1,2,3,0; no port is granted twice in succession.
REQ-036 Timeout: p_req[1]=1 with sd_ready never asserted -> p_ack[1] at TIMEOUT+1 cycles after the ISSUE entry, p_dout=0, timeout_err=1 until reset.
REQ-037 Refresh: idle for 480 cycles after reset -> one do_refresh pulse, then the next after 480 more; p_req[0] asserted in the threshold cycle -> request is issued and do_refresh is deferred.
REQ-038 Reset in WAIT, then sd_ready -> no p_ack, state IDLE, all outputs 0.
REQ-039 Early drop: p_req[3] dropped the cycle after grant -> transaction completes, p_ack[3] pulses once, no second sd_req.
